// File: rtl/rs_alu_queue_if.sv
// Dispatch, result-bus and ALU-issue signals of the ALU reservation station.
// slave is the station's view; master is the surrounding pipeline's view.
interface rs_alu_queue_if #(
  parameter int ROB_W = 4
) ();
  logic             issue_valid;
  logic [6:0]       issue_opcode;
  logic [2:0]       issue_funct3;
  logic             issue_funct7;
  logic             issue_rs1_busy;
  logic [ROB_W-1:0] issue_rs1_rob;
  logic [31:0]      issue_rs1_val;
  logic             issue_rs2_busy;
  logic [ROB_W-1:0] issue_rs2_rob;
  logic [31:0]      issue_rs2_val;
  logic [31:0]      issue_imm;
  logic [31:0]      issue_pc;
  logic [ROB_W-1:0] issue_rob_pos;
  logic             full;

  logic             alu_result;
  logic [ROB_W-1:0] alu_result_rob_pos;
  logic [31:0]      alu_result_val;
  logic             lsb_result;
  logic [ROB_W-1:0] lsb_result_rob_pos;
  logic [31:0]      lsb_result_val;

  logic             alu_en;
  logic [6:0]       alu_opcode;
  logic [2:0]       alu_funct3;
  logic             alu_funct7;
  logic [31:0]      alu_val1;
  logic [31:0]      alu_val2;
  logic [31:0]      alu_imm;
  logic [31:0]      alu_pc;
  logic [ROB_W-1:0] alu_rob_pos;

  modport slave (
    input  issue_valid, issue_opcode, issue_funct3, issue_funct7,
           issue_rs1_busy, issue_rs1_rob, issue_rs1_val,
           issue_rs2_busy, issue_rs2_rob, issue_rs2_val,
           issue_imm, issue_pc, issue_rob_pos,
           alu_result, alu_result_rob_pos, alu_result_val,
           lsb_result, lsb_result_rob_pos, lsb_result_val,
    output full,
           alu_en, alu_opcode, alu_funct3, alu_funct7,
           alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos
  );

  modport master (
    output issue_valid, issue_opcode, issue_funct3, issue_funct7,
           issue_rs1_busy, issue_rs1_rob, issue_rs1_val,
           issue_rs2_busy, issue_rs2_rob, issue_rs2_val,
           issue_imm, issue_pc, issue_rob_pos,
           alu_result, alu_result_rob_pos, alu_result_val,
           lsb_result, lsb_result_rob_pos, lsb_result_val,
    input  full,
           alu_en, alu_opcode, alu_funct3, alu_funct7,
           alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos
  );
endinterface

// File: rtl/rs_alu_queue.sv
// ALU reservation station: holds dispatched ALU-class instructions until both operands are known,
// snoops the ALU/LSB result buses, and issues the lowest-index ready entry to the ALU each cycle.
module rs_alu_queue #(
  parameter int RS_SIZE = 16,
  parameter int ROB_W   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          rollback,
  rs_alu_queue_if.slave bus
);
  localparam int IDX_W = $clog2(RS_SIZE);

  typedef struct packed {
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             funct7;
    logic             wait1;
    logic             wait2;
    logic [ROB_W-1:0] q1;
    logic [ROB_W-1:0] q2;
    logic [31:0]      v1;
    logic [31:0]      v2;
    logic [31:0]      imm;
    logic [31:0]      pc;
    logic [ROB_W-1:0] rob_pos;
  } entry_t;

  typedef struct packed {
    logic             valid;
    logic [ROB_W-1:0] tag;
    logic [31:0]      val;
  } cdb_t;

  typedef struct packed {
    logic        hit;
    logic [31:0] val;
  } snoop_t;

  // ALU bus wins when both buses carry the same tag (never legal upstream).
  function automatic snoop_t snoop(input logic [ROB_W-1:0] tag, input cdb_t alu, input cdb_t lsb);
    snoop_t s;
    s.hit = 1'b0;
    s.val = '0;
    if (alu.valid && alu.tag == tag) begin
      s.hit = 1'b1;
      s.val = alu.val;
    end else if (lsb.valid && lsb.tag == tag) begin
      s.hit = 1'b1;
      s.val = lsb.val;
    end
    return s;
  endfunction

  entry_t             ent_q [RS_SIZE];
  logic [RS_SIZE-1:0] busy_q;
  logic [RS_SIZE-1:0] busy_next;
  logic               full_q;
  logic               alloc;
  logic [IDX_W-1:0]   free_idx;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  cdb_t               alu_cdb;
  cdb_t               lsb_cdb;
  snoop_t             wake1 [RS_SIZE];
  snoop_t             wake2 [RS_SIZE];
  snoop_t             iss1;
  snoop_t             iss2;
  entry_t             new_ent;

  assign full_q   = &busy_q;
  assign bus.full = full_q;
  assign alloc    = bus.issue_valid && !full_q;

  assign alu_cdb = '{valid: bus.alu_result, tag: bus.alu_result_rob_pos, val: bus.alu_result_val};
  assign lsb_cdb = '{valid: bus.lsb_result, tag: bus.lsb_result_rob_pos, val: bus.lsb_result_val};

  // Priority encoders scan downward so the last hit seen is the lowest index.
  // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
  always_comb begin
    free_idx  = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IDX_W'(i);
      if (busy_q[i] && !ent_q[i].wait1 && !ent_q[i].wait2) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      wake1[i] = snoop(ent_q[i].q1, alu_cdb, lsb_cdb);
      wake2[i] = snoop(ent_q[i].q2, alu_cdb, lsb_cdb);
    end
  end

  // Dispatch-time bypass: an operand whose producer is on a bus this cycle is stored already resolved.
  always_comb begin
    iss1            = snoop(bus.issue_rs1_rob, alu_cdb, lsb_cdb);
    iss2            = snoop(bus.issue_rs2_rob, alu_cdb, lsb_cdb);
    new_ent.opcode  = bus.issue_opcode;
    new_ent.funct3  = bus.issue_funct3;
    new_ent.funct7  = bus.issue_funct7;
    new_ent.q1      = bus.issue_rs1_rob;
    new_ent.q2      = bus.issue_rs2_rob;
    new_ent.wait1   = bus.issue_rs1_busy && !iss1.hit;
    new_ent.wait2   = bus.issue_rs2_busy && !iss2.hit;
    new_ent.v1      = bus.issue_rs1_busy ? iss1.val : bus.issue_rs1_val;
    new_ent.v2      = bus.issue_rs2_busy ? iss2.val : bus.issue_rs2_val;
    new_ent.imm     = bus.issue_imm;
    new_ent.pc      = bus.issue_pc;
    new_ent.rob_pos = bus.issue_rob_pos;
  end

  // The free slot comes from registered busy bits, so a slot vacated by this edge's issue is never refilled here.
  // NOTE: combinational next-state uses blocking '=' so later lines see earlier updates; flops below use '<='.
  always_comb begin
    busy_next = busy_q;
    if (sel_found) busy_next[sel_idx] = 1'b0;
    if (alloc)     busy_next[free_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q          <= '0;
      bus.alu_en      <= 1'b0;
      bus.alu_opcode  <= '0;
      bus.alu_funct3  <= '0;
      bus.alu_funct7  <= 1'b0;
      bus.alu_val1    <= '0;
      bus.alu_val2    <= '0;
      bus.alu_imm     <= '0;
      bus.alu_pc      <= '0;
      bus.alu_rob_pos <= '0;
    end else if (rdy) begin
      if (rollback) begin
        busy_q     <= '0;
        bus.alu_en <= 1'b0;
      end else begin
        busy_q     <= busy_next;
        bus.alu_en <= sel_found;
        if (sel_found) begin
          bus.alu_opcode  <= ent_q[sel_idx].opcode;
          bus.alu_funct3  <= ent_q[sel_idx].funct3;
          bus.alu_funct7  <= ent_q[sel_idx].funct7;
          bus.alu_val1    <= ent_q[sel_idx].v1;
          bus.alu_val2    <= ent_q[sel_idx].v2;
          bus.alu_imm     <= ent_q[sel_idx].imm;
          bus.alu_pc      <= ent_q[sel_idx].pc;
          bus.alu_rob_pos <= ent_q[sel_idx].rob_pos;
        end
      end
    end
  end

  // NOTE: entry payload has no reset; busy_q alone decides whether a slot's contents mean anything.
  always_ff @(posedge clk) begin
    if (rdy && !rollback) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i] && ent_q[i].wait1 && wake1[i].hit) begin
          ent_q[i].wait1 <= 1'b0;
          ent_q[i].v1    <= wake1[i].val;
        end
        if (busy_q[i] && ent_q[i].wait2 && wake2[i].hit) begin
          ent_q[i].wait2 <= 1'b0;
          ent_q[i].v2    <= wake2[i].val;
        end
      end
      if (alloc) ent_q[free_idx] <= new_ent;
    end
  end
endmodule

// File: tb/tb_rs_alu_queue.sv
// Self-checking bench for rs_alu_queue: directed scenarios plus a randomized run, all compared against
// a slot-level reference model of the reservation station.
module tb_rs_alu_queue;
  localparam int N  = 16;
  localparam int RW = 4;

  logic clk, rst, rdy, rollback;
  int   checks = 0;
  int   errors = 0;

  rs_alu_queue_if #(.ROB_W(RW)) bus ();

  rs_alu_queue #(.RS_SIZE(N), .ROB_W(RW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic          en;
    logic [6:0]    op;
    logic [2:0]    f3;
    logic          f7;
    logic [31:0]   v1;
    logic [31:0]   v2;
    logic [31:0]   imm;
    logic [31:0]   pc;
    logic [RW-1:0] rob;
  } out_t;

  typedef struct {
    bit            busy;
    bit            w1;
    bit            w2;
    logic [RW-1:0] q1;
    logic [RW-1:0] q2;
    logic [31:0]   v1;
    logic [31:0]   v2;
    out_t          ins;
  } slot_t;

  slot_t m [N];
  out_t  exp_o = '0;

  function automatic bit model_full();
    foreach (m[i]) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  function automatic out_t dut_out();
    return '{en: bus.alu_en, op: bus.alu_opcode, f3: bus.alu_funct3, f7: bus.alu_funct7,
             v1: bus.alu_val1, v2: bus.alu_val2, imm: bus.alu_imm, pc: bus.alu_pc, rob: bus.alu_rob_pos};
  endfunction

  function automatic bit snooped(input logic [RW-1:0] t, output logic [31:0] v);
    v = '0;
    if (bus.alu_result && bus.alu_result_rob_pos == t) begin v = bus.alu_result_val; return 1'b1; end
    if (bus.lsb_result && bus.lsb_result_rob_pos == t) begin v = bus.lsb_result_val; return 1'b1; end
    return 1'b0;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    int pick;
    int slot;
    logic [31:0] v;
    pick = -1;
    slot = -1;
    if (rst) begin
      foreach (m[i]) m[i].busy = 1'b0;
      exp_o = '0;
      return;
    end
    if (!rdy) return;
    if (rollback) begin
      foreach (m[i]) m[i].busy = 1'b0;
      exp_o.en = 1'b0;
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (pick < 0 && m[i].busy && !m[i].w1 && !m[i].w2) pick = i;
      if (slot < 0 && !m[i].busy) slot = i;
    end
    for (int i = 0; i < N; i++) begin
      if (m[i].busy && m[i].w1 && snooped(m[i].q1, v)) begin m[i].w1 = 1'b0; m[i].v1 = v; end
      if (m[i].busy && m[i].w2 && snooped(m[i].q2, v)) begin m[i].w2 = 1'b0; m[i].v2 = v; end
    end
    if (pick >= 0) begin
      exp_o    = m[pick].ins;
      exp_o.v1 = m[pick].v1;
      exp_o.v2 = m[pick].v2;
      exp_o.en = 1'b1;
      m[pick].busy = 1'b0;
    end else begin
      exp_o.en = 1'b0;
    end
    if (bus.issue_valid) begin
      checks++;
      if (slot < 0) begin
        errors++;
        $display("FAIL protocol: issue_valid=1 while station full (required issue_valid=0)");
      end else begin
        m[slot].busy = 1'b1;
        m[slot].w1 = bus.issue_rs1_busy;
        m[slot].q1 = bus.issue_rs1_rob;
        m[slot].v1 = bus.issue_rs1_val;
        m[slot].w2 = bus.issue_rs2_busy;
        m[slot].q2 = bus.issue_rs2_rob;
        m[slot].v2 = bus.issue_rs2_val;
        if (m[slot].w1 && snooped(m[slot].q1, v)) begin m[slot].w1 = 1'b0; m[slot].v1 = v; end
        if (m[slot].w2 && snooped(m[slot].q2, v)) begin m[slot].w2 = 1'b0; m[slot].v2 = v; end
        m[slot].ins = '{en: 1'b1, op: bus.issue_opcode, f3: bus.issue_funct3, f7: bus.issue_funct7,
                        v1: 32'd0, v2: 32'd0, imm: bus.issue_imm, pc: bus.issue_pc, rob: bus.issue_rob_pos};
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rdy = 1'b1;
    rollback = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_opcode = '0;
    bus.issue_funct3 = '0;
    bus.issue_funct7 = 1'b0;
    bus.issue_rs1_busy = 1'b0;
    bus.issue_rs1_rob = '0;
    bus.issue_rs1_val = '0;
    bus.issue_rs2_busy = 1'b0;
    bus.issue_rs2_rob = '0;
    bus.issue_rs2_val = '0;
    bus.issue_imm = '0;
    bus.issue_pc = '0;
    bus.issue_rob_pos = '0;
    bus.alu_result = 1'b0;
    bus.alu_result_rob_pos = '0;
    bus.alu_result_val = '0;
    bus.lsb_result = 1'b0;
    bus.lsb_result_rob_pos = '0;
    bus.lsb_result_val = '0;
  endtask

  task automatic set_issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic b1, input logic [RW-1:0] q1, input logic [31:0] v1,
                           input logic b2, input logic [RW-1:0] q2, input logic [31:0] v2,
                           input logic [31:0] imm, input logic [31:0] pc, input logic [RW-1:0] rob);
    bus.issue_valid = 1'b1;
    bus.issue_opcode = op;
    bus.issue_funct3 = f3;
    bus.issue_funct7 = f7;
    bus.issue_rs1_busy = b1;
    bus.issue_rs1_rob = q1;
    bus.issue_rs1_val = v1;
    bus.issue_rs2_busy = b2;
    bus.issue_rs2_rob = q2;
    bus.issue_rs2_val = v2;
    bus.issue_imm = imm;
    bus.issue_pc = pc;
    bus.issue_rob_pos = rob;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    set_issue(7'b0010011, 3'd0, 1'b0, 1'b0, 4'd0, 32'hdead, 1'b0, 4'd0, 32'd0, 32'd1, 32'd0, 4'd1);
    step();
    step();
    checks++;
    if ({bus.full, dut_out()} !== {1'b0, 145'd0}) begin
      errors++;
      $display("FAIL reset_outputs: got %h required all zero", {bus.full, dut_out()});
    end
    idle();
    rst = 1'b0;
    step();
    checks++;
    if ({bus.full, dut_out()} !== {model_full(), exp_o}) begin
      errors++;
      $display("FAIL reset_release: got %h required %h", {bus.full, dut_out()}, {model_full(), exp_o});
    end
  endtask

  task automatic test_addi();
    set_issue(7'b0010011, 3'd0, 1'b0, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd0, 32'd3, 32'h100, 4'd2);
    step();
    idle();
    checks++;
    if ({bus.alu_en, bus.full} !== 2'b00) begin
      errors++;
      $display("FAIL addi_edge1: alu_en/full=%b required 00", {bus.alu_en, bus.full});
    end
    step();
    checks++;
    if ({bus.alu_en, bus.alu_val1, bus.alu_imm, bus.alu_rob_pos, bus.full} !== {1'b1, 32'd5, 32'd3, 4'd2, 1'b0}) begin
      errors++;
      $display("FAIL addi_issue: en=%b val1=%h imm=%h rob=%0d full=%b required en=1 val1=5 imm=3 rob=2 full=0",
               bus.alu_en, bus.alu_val1, bus.alu_imm, bus.alu_rob_pos, bus.full);
    end
    checks++;
    if ({bus.full, dut_out()} !== {model_full(), exp_o}) begin
      errors++;
      $display("FAIL addi_model: got %h required %h", {bus.full, dut_out()}, {model_full(), exp_o});
    end
    step();
  endtask

  task automatic test_wakeup();
    set_issue(7'b0110011, 3'd0, 1'b0, 1'b1, 4'd7, 32'd0, 1'b0, 4'd0, 32'd1, 32'd0, 32'h200, 4'd8);
    step();
    idle();
    step();
    step();
    checks++;
    if (bus.alu_en !== 1'b0) begin
      errors++;
      $display("FAIL wakeup_blocked: alu_en=%b required 0", bus.alu_en);
    end
    bus.alu_result = 1'b1;
    bus.alu_result_rob_pos = 4'd7;
    bus.alu_result_val = 32'h10;
    step();
    idle();
    checks++;
    if (bus.alu_en !== 1'b0) begin
      errors++;
      $display("FAIL wakeup_no_bypass: alu_en=%b required 0 on wake edge", bus.alu_en);
    end
    step();
    checks++;
    if ({bus.alu_en, bus.alu_val1, bus.alu_val2, bus.alu_rob_pos} !== {1'b1, 32'h10, 32'd1, 4'd8}) begin
      errors++;
      $display("FAIL wakeup_issue: en=%b val1=%h val2=%h rob=%0d required en=1 val1=10 val2=1 rob=8",
               bus.alu_en, bus.alu_val1, bus.alu_val2, bus.alu_rob_pos);
    end
    step();
  endtask

  task automatic test_bypass();
    set_issue(7'b0110011, 3'd7, 1'b1, 1'b0, 4'd0, 32'h3, 1'b1, 4'd4, 32'd0, 32'd0, 32'h300, 4'd5);
    bus.lsb_result = 1'b1;
    bus.lsb_result_rob_pos = 4'd4;
    bus.lsb_result_val = 32'hFF;
    step();
    idle();
    step();
    checks++;
    if ({bus.alu_en, bus.alu_val2, bus.alu_funct3, bus.alu_funct7} !== {1'b1, 32'hFF, 3'd7, 1'b1}) begin
      errors++;
      $display("FAIL bypass_issue: en=%b val2=%h f3=%0d f7=%b required en=1 val2=ff f3=7 f7=1",
               bus.alu_en, bus.alu_val2, bus.alu_funct3, bus.alu_funct7);
    end
    step();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 9; k++) begin
      idle();
      if (k < 8) set_issue(7'b0110111, 3'd0, 1'b0, 1'b0, 4'd0, 32'(k), 1'b0, 4'd0, 32'd0, 32'(k * 16), 32'(k * 4), 4'(k));
      step();
      if (k > 0) begin
        checks++;
        if ({bus.alu_en, bus.alu_rob_pos} !== {1'b1, 4'(k - 1)}) begin
          errors++;
          $display("FAIL b2b_%0d: en=%b rob=%0d required en=1 rob=%0d", k, bus.alu_en, bus.alu_rob_pos, k - 1);
        end
      end
    end
    idle();
    step();
    checks++;
    if (bus.alu_en !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: alu_en=%b required 0", bus.alu_en);
    end
  endtask

  task automatic test_full();
    for (int k = 0; k < N; k++) begin
      idle();
      set_issue(7'b1100011, 3'd1, 1'b0, 1'b1, 4'(k), 32'd0, 1'b0, 4'd0, 32'(k), 32'(k), 32'h400, 4'(k));
      step();
      checks++;
      if ({bus.full, dut_out()} !== {model_full(), exp_o}) begin
        errors++;
        $display("FAIL fill_%0d: got %h required %h", k, {bus.full, dut_out()}, {model_full(), exp_o});
      end
    end
    idle();
    checks++;
    if (bus.full !== 1'b1) begin
      errors++;
      $display("FAIL full_set: full=%b required 1", bus.full);
    end
    bus.alu_result = 1'b1;
    bus.alu_result_rob_pos = 4'd9;
    bus.alu_result_val = 32'h99;
    step();
    idle();
    step();
    checks++;
    if ({bus.alu_en, bus.alu_rob_pos, bus.alu_val1, bus.full} !== {1'b1, 4'd9, 32'h99, 1'b0}) begin
      errors++;
      $display("FAIL full_wake9: en=%b rob=%0d val1=%h full=%b required en=1 rob=9 val1=99 full=0",
               bus.alu_en, bus.alu_rob_pos, bus.alu_val1, bus.full);
    end
    rollback = 1'b1;
    step();
    idle();
  endtask

  task automatic test_in_order();
    for (int k = 0; k < 3; k++) begin
      idle();
      set_issue(7'b0010111, 3'd0, 1'b0, 1'b0, 4'd0, 32'(k), 1'b1, 4'd5, 32'd0, 32'd0, 32'h500, 4'(10 + k));
      step();
    end
    idle();
    bus.alu_result = 1'b1;
    bus.alu_result_rob_pos = 4'd5;
    bus.alu_result_val = 32'h55;
    step();
    idle();
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (bus.alu_en !== (k < 3) || (k < 3 && bus.alu_rob_pos !== 4'(10 + k))) begin
        errors++;
        $display("FAIL in_order_%0d: en=%b rob=%0d required en=%0d rob=%0d",
                 k, bus.alu_en, bus.alu_rob_pos, k < 3, 10 + k);
      end
    end
  endtask

  task automatic test_rollback();
    for (int k = 0; k < 6; k++) begin
      idle();
      if (k == 4) set_issue(7'b1101111, 3'd0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd8, 32'h600, 4'd14);
      else        set_issue(7'b1100111, 3'd0, 1'b0, 1'b1, 4'd3, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 32'h600, 4'(k));
      step();
    end
    idle();
    checks++;
    if ({bus.alu_en, bus.alu_rob_pos} !== {1'b1, 4'd14}) begin
      errors++;
      $display("FAIL rollback_setup: en=%b rob=%0d required en=1 rob=14", bus.alu_en, bus.alu_rob_pos);
    end
    rollback = 1'b1;
    set_issue(7'b0010011, 3'd0, 1'b0, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd0, 32'd0, 32'h700, 4'd15);
    step();
    idle();
    checks++;
    if ({bus.alu_en, bus.full} !== 2'b00) begin
      errors++;
      $display("FAIL rollback_flush: en/full=%b required 00", {bus.alu_en, bus.full});
    end
    bus.alu_result = 1'b1;
    bus.alu_result_rob_pos = 4'd3;
    bus.alu_result_val = 32'h33;
    for (int k = 0; k < 4; k++) begin
      step();
      idle();
      checks++;
      if (bus.alu_en !== 1'b0) begin
        errors++;
        $display("FAIL rollback_no_issue_%0d: alu_en=%b required 0", k, bus.alu_en);
      end
    end
  endtask

  task automatic test_rdy_hold();
    set_issue(7'b0110011, 3'd2, 1'b0, 1'b0, 4'd0, 32'hA, 1'b0, 4'd0, 32'hB, 32'd0, 32'h800, 4'd3);
    step();
    set_issue(7'b0110011, 3'd3, 1'b0, 1'b0, 4'd0, 32'hC, 1'b0, 4'd0, 32'hD, 32'd0, 32'h804, 4'd4);
    step();
    idle();
    rdy = 1'b0;
    rollback = 1'b1;
    set_issue(7'b0010011, 3'd0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 32'h900, 4'd9);
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({bus.alu_en, bus.alu_rob_pos, bus.alu_val1} !== {1'b1, 4'd3, 32'hA}) begin
        errors++;
        $display("FAIL rdy_hold_%0d: en=%b rob=%0d val1=%h required en=1 rob=3 val1=a",
                 k, bus.alu_en, bus.alu_rob_pos, bus.alu_val1);
      end
    end
    idle();
    step();
    checks++;
    if ({bus.alu_en, bus.alu_rob_pos, bus.alu_val2} !== {1'b1, 4'd4, 32'hD}) begin
      errors++;
      $display("FAIL rdy_resume: en=%b rob=%0d val2=%h required en=1 rob=4 val2=d",
               bus.alu_en, bus.alu_rob_pos, bus.alu_val2);
    end
    step();
  endtask

  task automatic test_random();
    logic [6:0] ops [7];
    ops = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    for (int k = 0; k < 3000; k++) begin
      idle();
      rdy = ($urandom_range(9) != 0);
      rollback = ($urandom_range(149) == 0);
      if (!model_full() && $urandom_range(1) == 1)
        set_issue(ops[$urandom_range(6)], 3'($urandom_range(7)), 1'($urandom_range(1)),
                  1'($urandom_range(1)), 4'($urandom_range(7)), $urandom,
                  1'($urandom_range(1)), 4'($urandom_range(7)), $urandom,
                  $urandom, $urandom, 4'($urandom_range(15)));
      if ($urandom_range(2) == 0) begin
        bus.alu_result = 1'b1;
        bus.alu_result_rob_pos = 4'($urandom_range(7));
        bus.alu_result_val = $urandom;
      end
      if ($urandom_range(2) == 0) begin
        bus.lsb_result = 1'b1;
        bus.lsb_result_rob_pos = 4'($urandom_range(7));
        bus.lsb_result_val = $urandom;
        if (bus.alu_result && bus.alu_result_rob_pos == bus.lsb_result_rob_pos) bus.lsb_result = 1'b0;
      end
      step();
      checks++;
      if ({bus.full, dut_out()} !== {model_full(), exp_o}) begin
        errors++;
        $display("FAIL random_%0d: got %h required %h", k, {bus.full, dut_out()}, {model_full(), exp_o});
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_addi();
    test_wakeup();
    test_bypass();
    test_back_to_back();
    test_full();
    test_in_order();
    test_rollback();
    test_rdy_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
